// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: imem request/response, redirect input and decode output.
// master is the fetch queue side, slave is the memory/decode/branch side.
interface inst_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_inst,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_inst, dec_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_inst,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_inst, dec_pc,
    output dec_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential PC generator plus in-order instruction FIFO feeding decode.
// Redirects flush the FIFO and drop responses that are still in flight.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  inst_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_tw;
  logic [AW-1:0] r_tr;
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_tag  [DEPTH];

  logic [CW:0]   w_sum;
  logic          w_req;
  logic          w_hs;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_redir;
  logic [CW-1:0] w_out_nx;
  logic          w_unused;

  assign w_redir  = bus.redirect_valid;
  assign w_sum    = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_req    = !rst && !w_redir && (w_sum < LIM);
  assign w_hs     = w_req && bus.imem_req_ready;
  // a response with nothing outstanding is a protocol error and ignored
  assign w_resp   = bus.imem_resp_valid && (r_out != '0);
  assign w_push   = w_resp && (r_drop == '0) && !w_redir;
  assign w_pop    = (r_cnt != '0) && bus.dec_ready;
  assign w_out_nx = r_out + CW'(w_hs) - CW'(w_resp);
  assign w_unused = ^bus.redirect_pc[1:0];

  assign bus.imem_req_valid = w_req;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.dec_valid      = (r_cnt != '0);
  assign bus.dec_inst       = bus.dec_valid ? r_inst[r_rp] : 32'h0;
  assign bus.dec_pc         = bus.dec_valid ? r_pc[r_rp]   : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_cnt      <= '0;
      r_out      <= '0;
      r_drop     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_tw       <= '0;
      r_tr       <= '0;
    end else begin
      r_out <= w_out_nx;
      if (w_hs)   r_tw <= r_tw + AW'(1);
      if (w_resp) r_tr <= r_tr + AW'(1);
      if (w_redir) begin
        r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
        r_drop     <= w_out_nx;
        r_cnt      <= '0;
        r_wp       <= '0;
        r_rp       <= '0;
      end else begin
        if (w_hs) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // storage arrays carry no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_hs) r_tag[r_tw] <= r_fetch_pc;
    if (!rst && w_push) begin
      r_inst[r_wp] <= bus.imem_resp_inst;
      r_pc[r_wp]   <= r_tag[r_tr];
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  inst_fetch_queue_if ifc();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        mr;
    logic        dr;
    logic        erv;
    logic [31:0] ea;
    logic        edv;
    logic [31:0] epc;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int lat     = 1;
  int last_due = 0;

  ent_t        fq[$];
  logic [31:0] oq[$];
  int          drop = 0;
  logic [31:0] mpc  = RESET_PC;
  mreq_t       mq[$];

  logic        s_rv;
  logic [31:0] s_addr;
  logic        s_dv;
  logic [31:0] s_inst;
  logic [31:0] s_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_total++;
    if (a !== e)
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    else
      n_pass++;
  endtask

  task automatic step(input logic r, input logic rv,
                      input logic [31:0] rpc, input logic mr,
                      input logic dr, input bit en);
    logic        resp;
    logic [31:0] rinst;
    logic        e_rv;
    logic        e_dv;
    logic        act_hs;
    logic [31:0] act_addr;
    logic [31:0] tag;
    @(negedge clk);
    rst = r;
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rpc;
    ifc.imem_req_ready = mr;
    ifc.dec_ready      = dr;
    resp  = !r && (mq.size() > 0) && (mq[0].due <= cyc);
    rinst = resp ? memfn(mq[0].addr) : $urandom;
    ifc.imem_resp_valid = resp;
    ifc.imem_resp_inst  = rinst;
    #1;
    e_rv = !r && !rv && ((fq.size() + oq.size()) < DEPTH);
    e_dv = fq.size() > 0;
    s_rv   = ifc.imem_req_valid;
    s_addr = ifc.imem_req_addr;
    s_dv   = ifc.dec_valid;
    s_inst = ifc.dec_inst;
    s_pc   = ifc.dec_pc;
    if (en) begin
      chk("req_valid", 32'(s_rv), 32'(e_rv));
      chk("req_addr", s_addr, mpc);
      chk("dec_valid", 32'(s_dv), 32'(e_dv));
      chk("dec_inst", s_inst, e_dv ? fq[0].inst : 32'h0);
      chk("dec_pc", s_pc, e_dv ? fq[0].pc : 32'h0);
    end
    act_hs   = s_rv && mr;
    act_addr = s_addr;
    @(posedge clk);
    if (r) begin
      fq.delete();
      oq.delete();
      mq.delete();
      drop     = 0;
      mpc      = RESET_PC;
      last_due = cyc;
    end else begin
      if (e_dv && dr && !rv) void'(fq.pop_front());
      if (resp) begin
        void'(mq.pop_front());
        if (oq.size() == 0) begin
          n_total++;
          $display("FAIL resp_protocol: response with 0 outstanding, expected >0");
        end else begin
          tag = oq.pop_front();
          if (rv) ;
          else if (drop > 0) drop--;
          else fq.push_back('{inst: rinst, pc: tag});
        end
      end
      if (rv) begin
        fq.delete();
        drop = oq.size();
        mpc  = {rpc[31:2], 2'b00};
      end
      if (e_rv && mr) begin
        oq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
      if (act_hs) begin
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        mq.push_back('{addr: act_addr, due: last_due});
      end
    end
    cyc++;
  endtask

  vec_t tbl[15];
  bit   found;
  int   nreq;

  initial begin
    tbl[0]  = '{1, 0, 0,         1, 1, 0, 32'h00,  0, 32'h000};
    tbl[1]  = '{0, 0, 0,         1, 1, 1, 32'h00,  0, 32'h000};
    tbl[2]  = '{0, 0, 0,         1, 1, 1, 32'h04,  0, 32'h000};
    tbl[3]  = '{0, 0, 0,         1, 1, 1, 32'h08,  1, 32'h000};
    tbl[4]  = '{0, 0, 0,         1, 1, 1, 32'h0C,  1, 32'h004};
    tbl[5]  = '{0, 0, 0,         1, 0, 1, 32'h10,  1, 32'h008};
    tbl[6]  = '{0, 0, 0,         1, 0, 1, 32'h14,  1, 32'h008};
    tbl[7]  = '{0, 0, 0,         1, 0, 0, 32'h18,  1, 32'h008};
    tbl[8]  = '{0, 0, 0,         1, 0, 0, 32'h18,  1, 32'h008};
    tbl[9]  = '{0, 0, 0,         1, 1, 0, 32'h18,  1, 32'h008};
    tbl[10] = '{0, 0, 0,         1, 1, 1, 32'h18,  1, 32'h00C};
    tbl[11] = '{0, 1, 32'h102,   1, 1, 0, 32'h1C,  1, 32'h010};
    tbl[12] = '{0, 0, 0,         1, 1, 1, 32'h100, 0, 32'h000};
    tbl[13] = '{0, 0, 0,         1, 1, 1, 32'h104, 0, 32'h000};
    tbl[14] = '{0, 0, 0,         1, 1, 1, 32'h108, 1, 32'h100};

    rst = 1'b1;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_resp_valid = 1'b0;
    ifc.imem_resp_inst  = 32'h0;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = 32'h0;
    ifc.dec_ready       = 1'b0;

    step(1, 0, 0, 1, 1, 0);
    lat = 1;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].mr, tbl[i].dr, 1);
      chk($sformatf("tbl%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].erv));
      chk($sformatf("tbl%0d_req_addr", i), s_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_dec_valid", i), 32'(s_dv), 32'(tbl[i].edv));
      chk($sformatf("tbl%0d_dec_pc", i), s_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_dec_inst", i), s_inst,
          tbl[i].edv ? memfn(tbl[i].epc) : 32'h0);
    end

    // redirect with two requests still in flight
    lat = 2;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1);
    step(0, 1, 32'h100, 1, 1, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 1, 1, 1);
      if (s_dv) found = 1;
    end
    chk("redir_seen", 32'(found), 32'd1);
    if (found) chk("redir_first_pc", s_pc, 32'h100);

    // address wrap-around
    lat = 1;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1);
    step(0, 1, 32'hFFFF_FFFE, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_addr1", s_addr, 32'h0);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 1, 1);
    chk("wrap_pc1", s_pc, 32'h0);

    // reset with three buffered entries
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 1, 0, 1);
      if (fq.size() == 3) found = 1;
    end
    chk("fill3_seen", 32'(found), 32'd1);
    step(1, 0, 0, 1, 0, 1);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0, 1);
      if (i == 0) begin
        chk("rst_dec_valid", 32'(s_dv), 32'd0);
        chk("rst_req_addr", s_addr, RESET_PC);
      end
      if (s_rv) nreq++;
    end
    chk("rst_credit", 32'(nreq), 32'(DEPTH));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      lat = $urandom_range(1, 4);
      rpc = ($urandom_range(0, 3) == 0) ?
            (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Producer side of the decoder's instruction input. Generates sequential fetch PCs and issues read requests to instruction memory.
- Buffers returned instruction words in order in a small FIFO and presents one 32-bit instruction plus its PC per cycle to decode with a valid/ready handshake.
- Accepts redirects from the NPC/branch logic: flushes buffered words and discards responses still in flight.

Parameters:
- DEPTH, 4, FIFO entries and maximum (occupancy + outstanding requests); power of two, 2..16
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response word valid; in request order, no backpressure
- imem_resp_inst  in  32  returned instruction word
- redirect_valid  in  1  control-flow redirect (branch/jal/jalr taken)
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, treated as 00
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode consumes instruction
- dec_inst  out  32  instruction word to decoder
- dec_pc  out  32  PC of dec_inst

Behaviour:
- Reset (rst=1 at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0
  - imem_req_valid=0, dec_valid=0, dec_inst=0, dec_pc=0
- Request generation:
  - imem_req_valid=1 iff !rst && !redirect_valid && (occupancy+outstanding) < DEPTH.
  - imem_req_addr=fetch_pc.
  - Request handshake (valid&&ready): fetch_pc+=4, wrapping modulo 2^32; outstanding+=1.
  - Once asserted, imem_req_valid and imem_req_addr stay stable until ready or a redirect.
- Response handling:
  - On each imem_resp_valid, outstanding-=1.
  - If drop>0: drop-=1 and the word is discarded.
  - Otherwise push {word, pc_tag} into the FIFO. pc_tag comes from a parallel PC-tag FIFO written at request handshake time, so PCs stay correct across wrap-around.
  - The credit rule guarantees the FIFO never overflows.
  - imem_resp_valid with outstanding=0 is a protocol violation: the word is ignored and the bench asserts on it.
- Decode output:
  - dec_valid = FIFO non-empty; dec_inst/dec_pc = head entry, combinational from the FIFO.
  - Pop on dec_valid&&dec_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty. Empty with a push gives dec_valid the next cycle; there is no bypass, so minimum fetch-to-decode latency is 1 cycle after the response.
- Redirect (redirect_valid=1 at a clock edge):
  - FIFO cleared; a pop in the same cycle has no extra effect.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - No request is issued that cycle.
  - drop = outstanding_next, which is outstanding minus any response this cycle.
  - A response arriving in the redirect cycle is discarded.
  - The first request to the new PC is issued the cycle after the redirect.
- Back-to-back redirects: the later one wins; drop is recomputed each time.
- Occupancy counter width: clog2(DEPTH)+1. outstanding and drop share that width and both saturate-check against DEPTH.
- Reset has priority over redirect. Reset mid-flight also drops nothing explicitly; memory must be reset in the same cycle.

Test Plan:
- Reset then always-ready memory with 1-cycle response latency, dec_ready=1 -> requests at 0x0,0x4,0x8,...; dec_pc sequence 0x0,0x4,0x8 at one per cycle after a 2-cycle fill; dec_inst matches memory.
- dec_ready=0 for 10 cycles -> exactly 4 words buffered, imem_req_valid=0 once occupancy+outstanding=4; release -> pops 4 in order with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding -> both stale responses discarded, next dec_pc=0x100, dec_valid low until the first new word arrives.
- Redirect in the same cycle as a response and a dec handshake -> response dropped, FIFO empty next cycle, next imem_req_addr=0x200 for redirect_pc=0x202.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000; dec_pc tags 0xFFFFFFFC then 0x0.
- rst asserted mid-stream with FIFO at 3 entries -> the next cycle has dec_valid=0, imem_req_addr=RESET_PC, and outstanding=0.
